// File: rtl/fe_hazard_ctrl_pkg.sv
// Shared decode constants and state encoding for the fetch/execute sequencing controller.
package fe_hazard_ctrl_pkg;

  localparam logic [11:0] NOP     = 12'h000;
  localparam logic [3:0]  OP_LD   = 4'hA;
  localparam logic [3:0]  OP_ST   = 4'hB;
  localparam logic [3:0]  OP_BR   = 4'hC;
  localparam logic [3:0]  OP_JMP  = 4'hD;
  localparam logic [3:0]  OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2
  } hz_state_t;

endpackage

// File: rtl/fe_hazard_ctrl.sv
// Sequences the two-stage fetch/execute pipeline: freezes on memory waits, squashes on
// taken control transfers, parks on HALT and counts stall cycles. Enables are Mealy.
module fe_hazard_ctrl
  import fe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [11:0]      instr_EX,
  input  logic             branch_taken_EX,
  input  logic             mem_ready,
  input  logic             resume,
  output logic             pc_write_enable,
  output logic             write_enable_FE,
  output logic             clear_FE,
  output logic             mem_req,
  output logic             mem_we,
  output logic             halted,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_count
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MEM_TIMEOUT);

  hz_state_t        state_q, state_d;
  logic [WW-1:0]    wcnt_q, wcnt_d;
  logic             st_q, st_d;
  logic             halted_q, halted_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic pcwe_c, wefe_c, clr_c, req_c, mwe_c;
  logic [3:0] op;
  logic unused_instr_bits;

  assign op                = instr_EX[11:8];
  assign unused_instr_bits = ^instr_EX[7:0];

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    st_d     = st_q;
    err_d    = err_q;
    stall_d  = stall_q;
    pcwe_c   = 1'b0;
    wefe_c   = 1'b0;
    clr_c    = 1'b0;
    req_c    = 1'b0;
    mwe_c    = 1'b0;

    unique case (state_q)
      RUN: begin
        unique case (op)
          OP_LD, OP_ST: begin
            req_c = 1'b1;
            mwe_c = (op == OP_ST);
            st_d  = (op == OP_ST);
            if (mem_ready) begin
              pcwe_c = 1'b1;
              wefe_c = 1'b1;
            end else begin
              state_d = MEM_WAIT;
              wcnt_d  = WW'(1);
            end
          end
          OP_JMP: begin
            pcwe_c = 1'b1;
            clr_c  = 1'b1;
          end
          OP_BR: begin
            pcwe_c = 1'b1;
            clr_c  = branch_taken_EX;
            wefe_c = !branch_taken_EX;
          end
          OP_HALT: state_d = HALTED;
          default: begin
            pcwe_c = 1'b1;
            wefe_c = 1'b1;
          end
        endcase
      end
      MEM_WAIT: begin
        // The register is frozen, so the store qualifier captured at issue is still valid.
        req_c = 1'b1;
        mwe_c = st_q;
        if (mem_ready) begin
          pcwe_c  = 1'b1;
          wefe_c  = 1'b1;
          state_d = RUN;
          wcnt_d  = '0;
        end else if (wcnt_q == WAIT_MAX) begin
          err_d   = 1'b1;
          state_d = HALTED;
          wcnt_d  = '0;
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end
      HALTED: begin
        if (resume && !err_q) begin
          pcwe_c  = 1'b1;
          wefe_c  = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    if ((state_q != HALTED) && !pcwe_c && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
    halted_d = (state_d == HALTED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      wcnt_q   <= '0;
      st_q     <= 1'b0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      st_q     <= st_d;
      halted_q <= halted_d;
      err_q    <= err_d;
      stall_q  <= stall_d;
    end
  end

  // Mealy outputs are masked by reset so nothing reaches the datapath while it is held.
  assign pc_write_enable = pcwe_c & rst_n;
  assign write_enable_FE = wefe_c & rst_n;
  assign clear_FE        = clr_c & rst_n;
  assign mem_req         = req_c & rst_n;
  assign mem_we          = mwe_c & rst_n;
  assign halted          = halted_q;
  assign mem_error       = err_q;
  assign stall_count     = stall_q;

endmodule

// File: tb/tb_fe_hazard_ctrl.sv
// Directed plus randomized bench for fe_hazard_ctrl, checked against a cycle model of the rules.
module tb_fe_hazard_ctrl;
  import fe_hazard_ctrl_pkg::*;

  localparam int TO   = 4;
  localparam int CW   = 5;
  localparam int SMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [11:0]   instr_EX = 12'h0;
  logic          branch_taken_EX = 1'b0;
  logic          mem_ready = 1'b0;
  logic          resume = 1'b0;
  logic          pc_write_enable, write_enable_FE, clear_FE, mem_req, mem_we;
  logic          halted, mem_error;
  logic [CW-1:0] stall_count;

  int compared = 0;
  int mismatched = 0;

  // Reference model: an outstanding access with its age, a parked flag, a sticky error.
  bit m_wait, m_halt, m_err, m_st;
  int m_age, m_stall;
  bit n_wait, n_halt, n_err, n_st;
  int n_age, n_stall;
  bit e_pcwe, e_wefe, e_clr, e_req, e_mwe;

  fe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .instr_EX(instr_EX), .branch_taken_EX(branch_taken_EX),
    .mem_ready(mem_ready), .resume(resume), .pc_write_enable(pc_write_enable),
    .write_enable_FE(write_enable_FE), .clear_FE(clear_FE), .mem_req(mem_req),
    .mem_we(mem_we), .halted(halted), .mem_error(mem_error), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_eval(input logic [11:0] ins, input logic br, input logic rdy,
                            input logic res);
    logic [3:0] o;
    o = ins[11:8];
    {e_pcwe, e_wefe, e_clr, e_req, e_mwe} = '0;
    n_wait = m_wait; n_halt = m_halt; n_err = m_err; n_st = m_st; n_age = m_age;
    if (m_halt) begin
      if (res && !m_err) begin
        e_pcwe = 1; e_wefe = 1; n_halt = 0;
      end
    end else if (m_wait) begin
      e_req = 1; e_mwe = m_st;
      if (rdy) begin
        e_pcwe = 1; e_wefe = 1; n_wait = 0;
      end else if (m_age == TO) begin
        n_wait = 0; n_halt = 1; n_err = 1;
      end else begin
        n_age = m_age + 1;
      end
    end else if (o == OP_LD || o == OP_ST) begin
      e_req = 1; e_mwe = (o == OP_ST); n_st = (o == OP_ST);
      if (rdy) begin
        e_pcwe = 1; e_wefe = 1;
      end else begin
        n_wait = 1; n_age = 1;
      end
    end else if (o == OP_JMP || (o == OP_BR && br)) begin
      e_pcwe = 1; e_clr = 1;
    end else if (o == OP_HALT) begin
      n_halt = 1;
    end else begin
      e_pcwe = 1; e_wefe = 1;
    end
    n_stall = (!m_halt && !e_pcwe) ? ((m_stall + 1 > SMAX) ? SMAX : m_stall + 1) : m_stall;
  endtask

  task automatic step(input logic [11:0] ins, input logic br, input logic rdy, input logic res);
    instr_EX = ins; branch_taken_EX = br; mem_ready = rdy; resume = res;
    #2;
    model_eval(ins, br, rdy, res);
    chk("pc_write_enable", pc_write_enable, e_pcwe);
    chk("write_enable_FE", write_enable_FE, e_wefe);
    chk("clear_FE", clear_FE, e_clr);
    chk("mem_req", mem_req, e_req);
    chk("mem_we", mem_we, e_mwe);
    chk("clr_we_exclusive", clear_FE & write_enable_FE, 0);
    @(posedge clk); #1;
    m_wait = n_wait; m_halt = n_halt; m_err = n_err; m_st = n_st; m_age = n_age;
    m_stall = n_stall;
    chk("halted", halted, m_halt);
    chk("mem_error", mem_error, m_err);
    chk("stall_count", stall_count, m_stall);
  endtask

  task automatic do_reset();
    rst_n = 0; instr_EX = 12'h123; branch_taken_EX = 1; mem_ready = 1; resume = 1;
    #1;
    chk("rst_pc_we", pc_write_enable, 0);
    chk("rst_we_fe", write_enable_FE, 0);
    chk("rst_clear", clear_FE, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_halted", halted, 0);
    chk("rst_mem_error", mem_error, 0);
    chk("rst_stall", stall_count, 0);
    m_wait = 0; m_halt = 0; m_err = 0; m_st = 0; m_age = 0; m_stall = 0;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  initial begin
    logic [3:0] ops [8];
    ops = '{4'h1, 4'h2, OP_LD, OP_ST, OP_BR, OP_JMP, OP_HALT, 4'h0};

    do_reset();
    for (int i = 0; i < 5; i++) step(12'h100 + 12'(i), 0, 0, 0);
    chk("alu_stall", stall_count, 0);

    step({OP_LD, 8'h11}, 0, 1, 0);
    chk("ld_zero_wait_stall", stall_count, 0);

    step({OP_ST, 8'h22}, 0, 0, 0);
    step({OP_ST, 8'h22}, 0, 0, 0);
    step({OP_ST, 8'h22}, 0, 0, 0);
    step({OP_ST, 8'h22}, 0, 1, 0);
    chk("st_wait3_stall", stall_count, 3);

    step({OP_BR, 8'h05}, 1, 0, 0);
    step(NOP, 0, 0, 0);
    step({OP_BR, 8'h05}, 0, 0, 0);
    step({OP_JMP, 8'h40}, 0, 0, 0);
    chk("branch_stall", stall_count, 3);

    step({OP_HALT, 8'h00}, 0, 0, 0);
    chk("halt_enter", halted, 1);
    step({OP_HALT, 8'h00}, 0, 0, 0);
    step({OP_HALT, 8'h00}, 0, 0, 1);
    chk("halt_leave", halted, 0);
    chk("halt_stall", stall_count, 4);

    for (int i = 0; i < TO + 1; i++) step({OP_LD, 8'h33}, 0, 0, 0);
    chk("timeout_err", mem_error, 1);
    chk("timeout_halt", halted, 1);
    step({OP_LD, 8'h33}, 0, 1, 1);
    chk("resume_ignored", halted, 1);
    do_reset();
    chk("err_cleared", mem_error, 0);

    step({OP_LD, 8'h44}, 0, 0, 0);
    step({OP_LD, 8'h44}, 0, 0, 0);
    do_reset();

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
      end else begin
        step({ops[$urandom_range(0, 7)], 8'($urandom)}, 1'($urandom),
             ($urandom_range(0, 9) < 4), ($urandom_range(0, 3) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fe_hazard_ctrl.md
# fe_hazard_ctrl

Pipeline sequencing controller for the two-stage fetch/execute core. Decodes the instruction held in the fetch-execute pipeline register and drives that register's write-enable and clear, the PC write-enable and the data-memory request handshake. It freezes the pipeline across multi-cycle memory accesses, squashes the wrong-path fetch on taken control transfers, parks the core on HALT, and counts stall cycles.

## Interface
- MEM_TIMEOUT, 255: maximum MEM_WAIT cycles before the access is aborted; range 1..65535.
- CNT_W, 16: width of the stall counter.
- clk  in  1  core clock, all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_EX  in  12  instruction currently in execute (fetch-execute register output); opcode is [11:8].
- branch_taken_EX  in  1  branch condition result; only meaningful when the opcode is OP_BR.
- mem_ready  in  1  data-memory acknowledge; completes the current access in the cycle it is high with mem_req.
- resume  in  1  single-cycle request to leave HALTED.
- pc_write_enable  out  1  PC register load enable.
- write_enable_FE  out  1  to the fetch-execute register write_enable_FE.
- clear_FE  out  1  to the fetch-execute register clear_FE (loads NOP).
- mem_req  out  1  data-memory request.
- mem_we  out  1  write qualifier; high with mem_req for OP_ST.
- halted  out  1  registered; high while in HALTED.
- mem_error  out  1  registered, sticky; set on memory timeout.
- stall_count  out  CNT_W  registered saturating stall-cycle count.

## Operation
- States: RUN, MEM_WAIT, HALTED. Reset state is RUN.
- Decode is of instr_EX[11:8] only. The enable outputs are Mealy (state plus current inputs).
- RUN, OP_LD/OP_ST: mem_req=1, mem_we=(OP_ST).
  - If mem_ready is high the same cycle, the access completes: pc_write_enable=1, write_enable_FE=1, stay in RUN.
  - Otherwise both enables are 0 and the next state is MEM_WAIT.
- MEM_WAIT: mem_req and mem_we are held from the instruction; pipeline frozen.
  - On mem_ready: advance as above and return to RUN.
  - A wait counter starts at 1 on entry. If it reaches MEM_TIMEOUT with mem_ready still low: set mem_error, deassert mem_req next cycle, go to HALTED with no advance.
- RUN, OP_JMP or (OP_BR and branch_taken_EX): pc_write_enable=1 (PC loads target), clear_FE=1, write_enable_FE=0.
- RUN, OP_BR not taken: normal advance.
- RUN, OP_HALT: both enables 0, next state HALTED.
- RUN, any other opcode: pc_write_enable=1, write_enable_FE=1.
- HALTED: all enables 0, mem_req=0.
  - On resume with mem_error=0: pc_write_enable=1 and write_enable_FE=1 (steps past the HALT), next state RUN.
  - resume is ignored while mem_error=1. Only reset clears mem_error.
- clear_FE and write_enable_FE are never both high.
- stall_count increments each cycle in RUN or MEM_WAIT where pc_write_enable=0. Branch-squash cycles are not counted; HALTED is not counted. It saturates at all-ones.

## Timing
- While rst_n is low, every output is 0 and the state is RUN. Deassertion takes effect at the next edge.
- Zero-wait memory: 0 stall cycles.
- Memory ready N cycles after the first request: N stall cycles, and mem_req is high for N+1 cycles.
- Taken branch or jump: 1-cycle penalty. The next cycle's instr_EX is NOP.
- halted and mem_error rise on the edge that enters HALTED. halted falls on the edge that leaves it.
- Timeout: mem_req is high for exactly MEM_TIMEOUT+1 cycles, then mem_error=1 on the following edge.
- A reset asserted mid-access drops mem_req immediately (async) and clears the wait counter, stall_count and mem_error.
- mem_ready is ignored outside a request.

## Structure
- Add to common_def: opcode constants OP_LD=4'hA, OP_ST=4'hB, OP_BR=4'hC, OP_JMP=4'hD, OP_HALT=4'hF, and enum hz_state_t {RUN, MEM_WAIT, HALTED}. The existing NOP remains the squash encoding.
- The module is flat; no sub-module is needed.
- Wait-counter width is $clog2(MEM_TIMEOUT+1).

## Test plan
- Reset, then ALU ops (opcode 4'h1) for 5 cycles -> pc_write_enable=write_enable_FE=1 every cycle, stall_count=0.
- OP_LD with mem_ready tied high -> advance in 1 cycle, mem_req high 1 cycle, stall_count unchanged.
- OP_ST with mem_ready asserted 3 cycles after the request -> 3 frozen cycles, mem_we=1 throughout, stall_count=3, then back to RUN.
- OP_BR with branch_taken_EX=1 -> clear_FE=1, pc_write_enable=1 for one cycle. With branch_taken_EX=0 -> normal advance.
- OP_HALT -> halted=1 next edge, enables 0. Pulse resume -> one advance cycle, halted=0.
- MEM_TIMEOUT=4, OP_LD with mem_ready never high -> mem_error=1, halted=1, resume ignored. Then rst_n low -> all outputs 0, mem_error cleared.
